// File: rtl/sys_row_feeder_if.sv
// WritePort row bus: valid/ready handshake carrying one LEN-wide row.
// master drives wvalid/wdata, slave returns wready.
interface sys_row_feeder_if #(
  parameter int LEN   = 6,
  parameter int WIDTH = 32
);
  logic             wvalid;
  logic             wready;
  logic [WIDTH-1:0] wdata [LEN];

  modport master (
    output wvalid,
    output wdata,
    input  wready
  );

  modport slave (
    input  wvalid,
    input  wdata,
    output wready
  );
endinterface

// File: rtl/sys_row_feeder.sv
// Row FIFO plus diagonal skew feeding the systolic array; lane i lags lane 0 by i.
// Ports: clk, rst_n, wp (row write bus), en, feed_value/feed_valid, level, busy.
module sys_row_feeder #(
  parameter int LEN   = 6,
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sys_row_feeder_if.slave      wp,
  input  logic                 en,
  output logic [WIDTH-1:0]     feed_value [LEN],
  output logic [LEN-1:0]       feed_valid,
  output logic [LW-1:0]        level,
  output logic                 busy
);

  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH][LEN];
  logic [WIDTH-1:0] head  [LEN];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          busy_q, busy_d;

  logic          wready;
  logic          push;
  logic          pop;
  logic [LEN-1:0] lane_nxt;

  // No bypass: a full FIFO refuses even when a pop happens this cycle.
  assign wready    = rst_n & (level_q < FULL);
  assign wp.wready = wready;
  assign push      = wp.wvalid & wready;
  assign pop       = en & (level_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign busy      = busy_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    busy_d = (level_d != '0) | (|lane_nxt);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wp.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      busy_q   <= busy_d;
    end
  end

  for (genvar i = 0; i < LEN; i++) begin : g_lane
    logic [WIDTH-1:0] val_q [i+1];
    logic [WIDTH-1:0] val_d [i+1];
    logic [i:0]       vld_q;
    logic [i:0]       vld_d;

    // Bubbles carry value 0 so invalid lanes always read as 0.
    always_comb begin
      val_d[0] = pop ? head[i] : '0;
      vld_d[0] = pop;
      for (int j = 1; j <= i; j++) begin
        val_d[j] = val_q[j-1];
        vld_d[j] = vld_q[j-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= i; j++) val_q[j] <= '0;
        vld_q <= '0;
      end else if (en) begin
        for (int j = 0; j <= i; j++) val_q[j] <= val_d[j];
        vld_q <= vld_d;
      end
    end

    assign feed_value[i] = val_q[i];
    assign feed_valid[i] = vld_q[i];
    assign lane_nxt[i]   = en ? (|vld_d) : (|vld_q);
  end

endmodule

// File: tb/tb_sys_row_feeder.sv
// Randomized bench for sys_row_feeder against a row-queue/history model.
// Model: FIFO of rows; lane i shows the row popped i enabled edges ago.
module tb_sys_row_feeder;

  localparam int LEN   = 6;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef logic [LEN-1:0][WIDTH-1:0] row_t;
  typedef struct packed {
    logic v;
    row_t d;
  } ent_t;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] fv [LEN];
  logic [LEN-1:0]   fvld;
  logic [2:0]       level;
  logic             busy;

  sys_row_feeder_if #(.LEN(LEN), .WIDTH(WIDTH)) wp ();

  sys_row_feeder #(
    .LEN(LEN), .WIDTH(WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wp         (wp.slave),
    .en         (en),
    .feed_value (fv),
    .feed_valid (fvld),
    .level      (level),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk;
  int   n_err;
  ent_t q_fifo [$];
  ent_t hist   [$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    ent_t x;
    int   idx;
    bit   any;
    chk("level", 64'(level), 64'(q_fifo.size()));
    any = 1'b0;
    foreach (hist[k]) any |= hist[k].v;
    chk("busy", 64'(busy), 64'(q_fifo.size() != 0 || any));
    for (int i = 0; i < LEN; i++) begin
      idx = hist.size() - 1 - i;
      x = (idx >= 0) ? hist[idx] : '0;
      chk($sformatf("vld%0d", i), 64'(fvld[i]), 64'(x.v));
      chk($sformatf("val%0d", i), 64'(fv[i]),
          64'(x.v ? x.d[i] : '0));
    end
  endtask

  task automatic step(input bit wv, input row_t row, input bit e);
    bit   acc;
    bit   pp;
    ent_t x;
    wp.wvalid = wv;
    for (int i = 0; i < LEN; i++) wp.wdata[i] = row[i];
    en = e;
    chk("wready", 64'(wp.wready), 64'(q_fifo.size() < DEPTH));
    acc = wv && (q_fifo.size() < DEPTH);
    pp  = e && (q_fifo.size() > 0);
    @(posedge clk);
    if (e) begin
      x = pp ? q_fifo.pop_front() : '0;
      hist.push_back(x);
      if (hist.size() > LEN) void'(hist.pop_front());
    end
    if (acc) q_fifo.push_back({1'b1, row});
    #1;
    check_outputs();
  endtask

  function automatic row_t rnd_row();
    row_t r;
    for (int i = 0; i < LEN; i++) r[i] = $urandom;
    return r;
  endfunction

  task automatic do_reset();
    #2;
    wp.wvalid = 1'b0;
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    q_fifo.delete();
    hist.delete();
    chk("rst_wready", 64'(wp.wready), 64'd0);
    check_outputs();
    @(posedge clk);
    #3;
    chk("rst_hold_wready", 64'(wp.wready), 64'd0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_wready", 64'(wp.wready), 64'd1);
    check_outputs();
  endtask

  row_t r;
  row_t one_to_six;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    en = 1'b0;
    wp.wvalid = 1'b0;
    for (int i = 0; i < LEN; i++) wp.wdata[i] = '0;
    one_to_six[0] = 32'h3F800000;
    one_to_six[1] = 32'h40000000;
    one_to_six[2] = 32'h40400000;
    one_to_six[3] = 32'h40800000;
    one_to_six[4] = 32'h40A00000;
    one_to_six[5] = 32'h40C00000;

    #3;
    chk("por_wready", 64'(wp.wready), 64'd0);
    check_outputs();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("por_rel_wready", 64'(wp.wready), 64'd1);

    // single row
    step(1'b1, one_to_six, 1'b1);
    repeat (10) step(1'b0, '0, 1'b1);

    // fill to full with drain stalled, then release
    for (int k = 0; k < 5; k++) begin
      r = rnd_row();
      step(1'b1, r, 1'b0);
    end
    chk("full_level", 64'(level), 64'd4);
    step(1'b1, r, 1'b1);
    step(1'b1, r, 1'b1);
    repeat (12) step(1'b0, '0, 1'b1);

    // streaming with pointer wrap
    for (int k = 0; k < 10; k++) step(1'b1, rnd_row(), 1'b1);
    repeat (10) step(1'b0, '0, 1'b1);

    // stall mid-skew
    step(1'b1, rnd_row(), 1'b1);
    repeat (3) step(1'b0, '0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0);
    repeat (8) step(1'b0, '0, 1'b1);

    // reset mid-operation
    for (int k = 0; k < 3; k++) step(1'b1, rnd_row(), 1'b0);
    step(1'b1, rnd_row(), 1'b1);
    step(1'b1, rnd_row(), 1'b1);
    do_reset();
    repeat (10) step(1'b0, '0, 1'b1);

    // empty drain
    repeat (20) step(1'b0, '0, 1'b1);

    // random traffic
    for (int k = 0; k < 400; k++)
      step(1'(($urandom_range(0, 99)) < 60), rnd_row(),
           1'(($urandom_range(0, 99)) < 70));
    repeat (15) step(1'b0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sys_row_feeder.md
# sys_row_feeder

Slave-side endpoint of the WritePort bus in front of the systolic array. It accepts `SYS_ARRAY_LEN`-wide rows of `NUMBER` values through the `wvalid`/`wready`/`wdata` handshake and buffers them in a small FIFO. It then drains one row per enabled cycle into a diagonal skew pipeline, so that lane i of the array receives its element i cycles after lane 0, tagged with the Scalar `valid` bit.

## Interface
Parameters:
- `LEN`, default `SYS_ARRAY_LEN` (6): lanes per row; equals `BUS_ARRAY_WIDTH`.
- `WIDTH`, default `NUMBER_WIDTH` (32): bits per element.
- `DEPTH`, default 4: FIFO depth in rows; a power of two, at least 2.

Ports:
- `clk`, input, 1: the only clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `wvalid`, input, 1: a write row is offered.
- `wready`, output, 1: the FIFO can accept a row.
- `wdata`, input, LEN x WIDTH: unpacked row; element i goes to lane i.
- `en`, input, 1: array advance enable; 0 stalls the drain and the skew pipeline.
- `feed_value`, output, LEN x WIDTH: per-lane value into array row inputs.
- `feed_valid`, output, LEN: per-lane Scalar valid flag.
- `level`, output, clog2(DEPTH)+1: FIFO occupancy in rows.
- `busy`, output, 1: set when `level` != 0 or any `feed_valid`/skew stage is valid.

## Operation
- **Write acceptance:** a row is accepted on a rising edge where `wvalid` and `wready` are both 1.
  - `wready` = (`level` < `DEPTH`) while `rst_n` is 1. It is forced to 0 while `rst_n` is 0.
  - There is no write-through bypass: when the FIFO is full, `wready` stays 0 even if a pop occurs in the same cycle.
- **Pop:** a row is popped on an edge where `en` = 1 and `level` > 0.
  - Element i of the popped row enters skew stage 0 of lane i with valid = 1.
  - If `en` = 1 and `level` = 0, a bubble (valid 0, value 0) enters every lane's stage 0.
- **Skew pipeline:** lane i has i+1 register stages, so lane 0 has 1 stage and lane LEN-1 has LEN stages.
  - `feed_value[i]` and `feed_valid[i]` are the last stage of lane i.
  - All stages of all lanes shift only when `en` = 1. When `en` = 0 everything holds, including outputs.
- **Simultaneous push and pop:** `level` is unchanged; both pointers advance.
- **Pointers:** read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Full/empty is decided from `level`, not from pointer equality.
- **Data handling:** values are passed bit-exact; no arithmetic is performed.
- **Invalid lanes:** the value of a lane whose valid is 0 is driven to 0.
- **Reset (asynchronous, any time, including mid-drain):** `level` = 0, pointers = 0, all skew stages cleared, `feed_valid` = 0, `feed_value` = 0, `busy` = 0, `wready` = 0. Buffered rows are discarded. FIFO storage contents need no reset.

## Timing
- **Write to pop:** a row accepted at edge E is visible in `level` after E and can be popped at edge E+1 at the earliest.
- **Pop to output:** for a row popped at edge P with `en` held at 1, `feed_valid[i]` = 1 with that row's element i during the cycle after edge P+i, for i = 0..LEN-1.
- **Stalls:** each cycle with `en` = 0 adds exactly one cycle to the remaining latency of every in-flight element.
- **Throughput:** one row per cycle when `wvalid` and `en` are held at 1 and the FIFO is neither empty nor full.
- **Draining:** `busy` falls the cycle after the last valid element leaves lane LEN-1 and `level` = 0.
- **Output type:** all outputs are registered except `wready`, which is combinational from `level` and `rst_n`.

## Test plan
- **Single row:** after reset, write row {1.0,2.0,3.0,4.0,5.0,6.0} (0x3F800000…0x40C00000) with `en` = 1.
  - Expect lane i valid with value i+1.0 exactly at cycle (accept edge + 1 + i), and exactly once per lane.
  - Expect `busy` low 6 cycles after the lane-0 output.
- **Fill to full:** hold `en` = 0 and write 5 rows.
  - Expect `wready` to drop after the 4th accept, `level` = 4, and the 5th row not accepted.
  - Raise `en`: expect rows to emerge in order, and the 5th row accepted the cycle after the first pop.
- **Streaming with wrap:** stream 10 rows with `wvalid` = `en` = 1.
  - Expect `level` ≤ 1, pointers wrapping twice, and every lane to see 10 contiguous valid beats in order with no bubbles.
- **Stall mid-skew:** pop one row, then drop `en` for 3 cycles while lanes 0–2 are out and lanes 3–5 are in flight.
  - Expect outputs frozen; lanes 3–5 appear 3 cycles later than in the unstalled case.
- **Reset mid-operation:** with 3 rows buffered and the skew pipeline partially full, pulse `rst_n` low between edges.
  - Expect immediately `feed_valid` = 0, `level` = 0, `busy` = 0, `wready` = 0.
  - After release, expect `wready` = 1 and no stale rows emitted.
- **Empty drain:** hold `en` = 1 with no writes for 20 cycles. Expect `feed_valid` = 0 and `feed_value` = 0 on all lanes throughout.
